// File: rtl/nes_pkg.sv
// Shared NES definitions for the CPU/PPU glue logic.
//   dma_state_t  : sprite OAM DMA sequencer states
//   OAM_DMA_REG  : CPU address whose write starts a sprite DMA
//   OAM_SIZE     : number of bytes in PPU sprite OAM (one full page)
package nes_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        READ,
        WRITE
    } dma_state_t;

    localparam logic [15:0] OAM_DMA_REG = 16'h4014;
    localparam int unsigned OAM_SIZE    = 256;

endpackage

// File: rtl/oam_dma_ctrl.sv
// Sprite OAM DMA sequencer ($4014). Halts the CPU via oam_dma (rdy = ~oam_dma),
// then copies CPU page {page,00..FF} into PPU OAM starting at OAMADDR, one
// READ/WRITE CPU-cycle pair per byte, with NES halt and odd-cycle alignment.
// Ports:
//   CLOCK_50, reset        : system clock, asynchronous active-high reset
//   cpu_ce                 : one-clock pulse per CPU cycle; state advances only on it
//   cpu_addr/data_out/we   : CPU bus, used to detect the $4014 trigger write
//   oam_start              : PPU OAMADDR, sampled at trigger
//   oam_dma                : DMA active (CPU halted)
//   dma_addr/dma_rd        : DMA read request into the CPU memory map
//   dma_data_in            : read data, valid at the cpu_ce ending READ
//   oam_addr/oam_data_in   : OAM write address/data
//   oam_we                 : OAM write strobe, coincident with cpu_ce in WRITE
//   busy_cnt               : CPU cycles spent with oam_dma high since trigger
module oam_dma_ctrl
    import nes_pkg::*;
#(
    parameter logic [15:0] DMA_REG_ADDR = OAM_DMA_REG,
    parameter bit          ALIGN_ODD    = 1'b1
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        cpu_ce,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_data_out,
    input  logic        cpu_we,
    input  logic [7:0]  oam_start,
    output logic        oam_dma,
    output logic [15:0] dma_addr,
    output logic        dma_rd,
    input  logic [7:0]  dma_data_in,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_data_in,
    output logic        oam_we,
    output logic [9:0]  busy_cnt
);

    localparam logic [7:0] LAST_BYTE = 8'(OAM_SIZE - 1);

    dma_state_t  state_q, state_d;
    logic        parity_q;
    logic [7:0]  page_q, page_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  oam_addr_q, oam_addr_d;
    logic [7:0]  data_q, data_d;
    logic [9:0]  busy_q, busy_d;
    logic        trigger;

    assign trigger = cpu_ce && cpu_we && (cpu_addr == DMA_REG_ADDR);

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            parity_q   <= 1'b0;
            page_q     <= '0;
            cnt_q      <= '0;
            oam_addr_q <= '0;
            data_q     <= '0;
            busy_q     <= '0;
        end else if (cpu_ce) begin
            state_q    <= state_d;
            parity_q   <= ~parity_q;
            page_q     <= page_d;
            cnt_q      <= cnt_d;
            oam_addr_q <= oam_addr_d;
            data_q     <= data_d;
            busy_q     <= busy_d;
        end
    end

    // Next-state values are only committed on cpu_ce, so nothing here needs to
    // look at cpu_ce except the trigger qualifier.
    always_comb begin
        state_d    = state_q;
        page_d     = page_q;
        cnt_d      = cnt_q;
        oam_addr_d = oam_addr_q;
        data_d     = data_q;
        busy_d     = busy_q;

        if (state_q != IDLE) begin
            busy_d = busy_q + 10'd1;
        end

        case (state_q)
            IDLE: begin
                if (trigger) begin
                    state_d    = HALT;
                    page_d     = cpu_data_out;
                    oam_addr_d = oam_start;
                    cnt_d      = '0;
                    busy_d     = '0;
                end
            end
            HALT: begin
                state_d = (ALIGN_ODD && parity_q) ? ALIGN : READ;
            end
            ALIGN: begin
                state_d = READ;
            end
            READ: begin
                data_d  = dma_data_in;
                state_d = WRITE;
            end
            WRITE: begin
                oam_addr_d = oam_addr_q + 8'd1;
                cnt_d      = cnt_q + 8'd1;
                state_d    = (cnt_q == LAST_BYTE) ? IDLE : READ;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign oam_dma     = (state_q != IDLE);
    assign dma_rd      = (state_q == READ);
    assign dma_addr    = (state_q == READ) ? {page_q, cnt_q} : '0;
    assign oam_we      = (state_q == WRITE) && cpu_ce;
    assign oam_addr    = oam_addr_q;
    assign oam_data_in = data_q;
    assign busy_cnt    = busy_q;

endmodule

// File: doc/oam_dma_ctrl.md
Name: oam_dma_ctrl

Overview:
- Sequencer for the sprite OAM DMA triggered by a CPU write to $4014.
- Sits between cpu_toplevel and ppu_toplevel in FPGA_NES.
- Halts the CPU through the existing oam_dma/rdy path, then copies 256 bytes from CPU page $XX00-$XXFF into PPU OAM.
- Uses one read/write CPU-cycle pair per byte, with NES-accurate halt and alignment cycles.

Parameters:
- DMA_REG_ADDR, 16'h4014, CPU address that triggers DMA.
- ALIGN_ODD, 1, when 1 insert one extra alignment cycle if the DMA starts on an odd CPU cycle.

Ports:
- CLOCK_50  in  1  system clock
- reset  in  1  asynchronous, active-high
- cpu_ce  in  1  one-CLOCK_50 pulse per CPU cycle; all state advances only when cpu_ce=1
- cpu_addr  in  16  CPU address bus
- cpu_data_out  in  8  CPU write data
- cpu_we  in  1  CPU write strobe, valid with cpu_ce
- oam_start  in  8  current PPU OAMADDR, sampled at trigger
- oam_dma  out  1  DMA active; top level drives rdy = ~oam_dma
- dma_addr  out  16  DMA read address driven to the CPU memory map
- dma_rd  out  1  DMA read request on dma_addr
- dma_data_in  in  8  read data, valid at the cpu_ce ending a READ cycle
- oam_addr  out  8  OAM write address
- oam_data_in  out  8  OAM write data
- oam_we  out  1  OAM write enable, one CLOCK_50 cycle wide, coincident with cpu_ce in WRITE
- busy_cnt  out  10  CPU cycles elapsed since trigger (debug/HEX)

Behaviour:
- Reset values (asynchronous):
  - state=IDLE
  - oam_dma=0, dma_rd=0, oam_we=0
  - dma_addr=16'h0000, oam_addr=8'h00, oam_data_in=8'h00
  - busy_cnt=0
  - parity flop=0, page reg=0, byte counter=0
- Parity flop toggles on every cpu_ce, including while DMA is active. Odd cycle = parity 1.
- Trigger:
  - Condition: state IDLE, cpu_ce=1, cpu_we=1, cpu_addr==DMA_REG_ADDR.
  - Latch page<=cpu_data_out and oam_addr<=oam_start; clear the byte counter.
  - Go to HALT; oam_dma asserts on the next CLOCK_50 edge.
- States and transitions (all taken on cpu_ce):
  - IDLE: outputs low; waits for trigger.
  - HALT: one dummy cycle in which the CPU finishes its write. Go to ALIGN if ALIGN_ODD=1 and parity=1, else to READ.
  - ALIGN: one dummy cycle, then READ.
  - READ: dma_rd=1, dma_addr={page,cnt}. At the ending cpu_ce capture oam_data_in<=dma_data_in, then go to WRITE.
  - WRITE: oam_we pulses on the cpu_ce of this cycle. On the same edge oam_addr increments mod 256 (wrap $FF->$00) and cnt increments. If cnt was 8'hFF go to IDLE, else READ.
- Leaving to IDLE deasserts oam_dma on the same edge, so the CPU resumes on the next cpu_ce.
- Total oam_dma high time is 513 CPU cycles (even start) or 514 (odd start).
- busy_cnt increments per cpu_ce while oam_dma=1, holds its final value in IDLE, and clears on a new trigger.
- Triggers while not IDLE are ignored (CPU is halted; defensive).
- Reset mid-transfer: immediate return to IDLE, oam_dma=0, no further oam_we. OAM contents already written stay.
- cpu_ce=0: every register holds.
- Source page $FF reads $FF00-$FFFF with no address carry.

Decomposition:
- Shared package nes_pkg:
  - typedef enum logic [2:0] dma_state_t {IDLE, HALT, ALIGN, READ, WRITE}
  - localparams OAM_DMA_REG=16'h4014, OAM_SIZE=256
- Single module; no sub-module needed. The parity flop could later move to a shared cpu_clk_gen, but stays local for now.

Test Plan:
- Even-start, write 8'h02 to $4014 with oam_start=0 -> oam_dma high exactly 513 cpu_ce; 256 oam_we pulses at oam_addr 0..255; reads $0200..$02FF in order.
- Odd-start, same write one cpu_ce later -> oam_dma high 514 cpu_ce; ALIGN visited once; busy_cnt ends at 514.
- oam_start=8'hFC, page 8'h03, RAM[$0300+i]=i -> byte 0 lands at OAM $FC; byte 4 at OAM $00 (wrap); OAM[$FB]=8'hFF.
- cpu_ce held low for 20 CLOCK_50 cycles mid-READ -> no state, address or counter change; resumes correctly.
- Assert reset at byte 100 -> oam_dma=0 and oam_we=0 immediately; a subsequent trigger with page 8'h07 restarts from {07,00} with busy_cnt=0.
- Write $4013 or a read of $4014 -> no trigger, oam_dma stays 0.
